poly_voice_mixer: RTL and testbench

Upstream feeder for the SPI DAC driver. On each sample request (the driver's `ena_out` pulse) it reads every voice sample from the voice engine's sample store and sums them in a pipeline. It scales the sum and clips it to 12 bits, then presents the result as offset-binary `dac_data`. `dac_data` connects to the driver's `data_in` and stays stable between updates.

---
 rtl/poly_voice_mixer.sv | 119 +++++++++++
 tb/tb_poly_voice_mixer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_voice_mixer.sv
// Sums all voice samples on each DAC sample request, scales, clips to 12 bits and outputs offset binary.
// Optional macro POLY_MIXER_SATURATE_EN selects saturating clip; default build wraps to 12 bits.
module poly_voice_mixer #(
   parameter int NVOICES = 8,
   parameter int VW      = 16,
   parameter int SHIFT   = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       sample_req,
   input  logic [NVOICES-1:0]         voice_mute,
   output logic                       voice_rd,
   output logic [$clog2(NVOICES)-1:0] voice_addr,
   input  logic signed [VW-1:0]       voice_data,
   output logic [11:0]                dac_data,
   output logic                       sample_strobe,
   output logic                       busy,
   output logic                       overrun
);

   localparam int ADDR_W = $clog2(NVOICES);
   localparam int ACC_W  = VW + ADDR_W;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]              state;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] term;
   logic signed [ACC_W-1:0] sum_next;
   logic                    data_valid;
   logic [ADDR_W-1:0]       data_idx;
   logic [11:0]             clipped;

   // data_valid/data_idx track which address the current voice_data belongs to
   always_comb begin
      term = '0;
      if (data_valid && !voice_mute[data_idx]) begin
         term = {{(ACC_W-VW){voice_data[VW-1]}}, voice_data};
      end
      sum_next = acc + term;
   end

`ifdef POLY_MIXER_SATURATE_EN
   localparam logic signed [ACC_W-1:0] CLIP_MAX = ACC_W'(2047);
   localparam logic signed [ACC_W-1:0] CLIP_MIN = ACC_W'(-2048);

   logic signed [ACC_W-1:0] scaled;

   always_comb begin
      scaled = sum_next >>> SHIFT;
      if (scaled > CLIP_MAX) begin
         clipped = 12'h7ff;
      end else if (scaled < CLIP_MIN) begin
         clipped = 12'h800;
      end else begin
         clipped = scaled[11:0];
      end
   end
`else
   assign clipped = 12'(sum_next >>> SHIFT);
`endif

   // The result is registered at the end of DRAIN so dac_data and the strobe appear in the DONE cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         acc           <= '0;
         voice_rd      <= 1'b0;
         voice_addr    <= '0;
         data_valid    <= 1'b0;
         data_idx      <= '0;
         dac_data      <= 12'h800;
         sample_strobe <= 1'b0;
         busy          <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         sample_strobe <= 1'b0;
         overrun       <= sample_req && busy;
         data_valid    <= voice_rd;
         data_idx      <= voice_addr;
         case (state)
            IDLE: begin
               acc <= '0;
               if (sample_req) begin
                  state      <= READ;
                  voice_rd   <= 1'b1;
                  voice_addr <= '0;
                  busy       <= 1'b1;
               end
            end
            READ: begin
               acc <= sum_next;
               if (voice_addr == ADDR_W'(NVOICES-1)) begin
                  voice_rd <= 1'b0;
                  state    <= DRAIN;
               end else begin
                  voice_addr <= voice_addr + 1'b1;
               end
            end
            DRAIN: begin
               acc           <= sum_next;
               dac_data      <= {~clipped[11], clipped[10:0]};
               sample_strobe <= 1'b1;
               state         <= DONE;
            end
            DONE: begin
               acc   <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Scoreboard bench for poly_voice_mixer: expected mixes, reads and overruns are queued at request time
// and retired by a negedge monitor. Honours POLY_MIXER_SATURATE_EN for expected clip behaviour.
module tb_poly_voice_mixer;

   localparam int NV    = 8;
   localparam int VW    = 16;
   localparam int SHIFT = 3;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 sample_req = 1'b0;
   logic [NV-1:0]        voice_mute = '0;
   logic                 voice_rd;
   logic [2:0]           voice_addr;
   logic signed [VW-1:0] voice_data;
   logic [11:0]          dac_data;
   logic                 sample_strobe;
   logic                 busy;
   logic                 overrun;

   logic signed [VW-1:0] voices [NV];

   typedef struct {int cyc; logic [11:0] dac;} mix_t;
   typedef struct {int cyc; int addr;} rd_t;

   mix_t sb[$];
   rd_t  rd_q[$];
   int   ovr_q[$];
   mix_t mix_e;
   rd_t  rd_e;
   int   ovr_e;

   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int          busy_from = -1;
   int          busy_until = -2;
   logic [11:0] dac_prev = 12'h800;

   poly_voice_mixer #(.NVOICES(NV), .VW(VW), .SHIFT(SHIFT)) dut (
      .clk(clk),
      .reset(reset),
      .sample_req(sample_req),
      .voice_mute(voice_mute),
      .voice_rd(voice_rd),
      .voice_addr(voice_addr),
      .voice_data(voice_data),
      .dac_data(dac_data),
      .sample_strobe(sample_strobe),
      .busy(busy),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Voice sample store: data valid the cycle after the read strobe
   always @(posedge clk or negedge reset) begin
      if (!reset) voice_data <= '0;
      else if (voice_rd) voice_data <= voices[voice_addr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%0h, wanted 0x%0h", tag, cyc, observed, expected);
      end
   endtask

   function automatic logic [11:0] model_dac(input logic [NV-1:0] mute);
      int sum = 0;
      int s;
      logic [11:0] r;
      for (int i = 0; i < NV; i++) if (!mute[i]) sum += int'(voices[i]);
      s = sum >>> SHIFT;
`ifdef POLY_MIXER_SATURATE_EN
      if (s > 2047) r = 12'h7ff;
      else if (s < -2048) r = 12'h800;
      else r = s[11:0];
`else
      r = s[11:0];
`endif
      return {~r[11], r[10:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Pulses sample_req for the current cycle and queues what the DUT should do about it
   task automatic applyStimulus(input bit accepted);
      int t;
      t = cyc;
      sample_req = 1'b1;
      if (accepted) begin
         sb.push_back('{t + NV + 2, model_dac(voice_mute)});
         for (int i = 0; i < NV; i++) rd_q.push_back('{t + 1 + i, i});
         busy_from  = t + 1;
         busy_until = t + NV + 2;
      end else begin
         ovr_q.push_back(t + 1);
      end
      step();
      sample_req = 1'b0;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 40 && sb.size() != 0; k++) step();
      if (sb.size() != 0) begin
         checkOutput("mix_timeout", sb.size(), 0);
         sb.delete();
      end
      checkOutput("reads_left", rd_q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         dac_prev = 12'h800;
      end else begin
         checkOutput("busy", busy, (cyc >= busy_from && cyc <= busy_until));
         if (voice_rd) begin
            if (rd_q.size() == 0) begin
               checkOutput("rd_spurious", 1, 0);
            end else begin
               rd_e = rd_q.pop_front();
               checkOutput("rd_cycle", cyc, rd_e.cyc);
               checkOutput("rd_addr", voice_addr, rd_e.addr);
            end
         end else if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
            rd_e = rd_q.pop_front();
            checkOutput("rd_missing", cyc, rd_e.cyc);
         end
         if (sample_strobe) begin
            if (sb.size() == 0) begin
               checkOutput("strobe_spurious", 1, 0);
            end else begin
               mix_e = sb.pop_front();
               checkOutput("strobe_cycle", cyc, mix_e.cyc);
               checkOutput("dac_data", dac_data, mix_e.dac);
            end
         end else begin
            checkOutput("dac_hold", dac_data, dac_prev);
            if (sb.size() != 0 && sb[0].cyc <= cyc) begin
               mix_e = sb.pop_front();
               checkOutput("strobe_missing", cyc, mix_e.cyc);
            end
         end
         if (overrun) begin
            if (ovr_q.size() == 0) begin
               checkOutput("overrun_spurious", 1, 0);
            end else begin
               ovr_e = ovr_q.pop_front();
               checkOutput("overrun_cycle", cyc, ovr_e);
            end
         end else if (ovr_q.size() != 0 && ovr_q[0] <= cyc) begin
            ovr_e = ovr_q.pop_front();
            checkOutput("overrun_missing", cyc, ovr_e);
         end
         dac_prev = dac_data;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t;
      for (int i = 0; i < NV; i++) voices[i] = '0;
      #1 reset = 1'b0;
      repeat (3) step();
      reset = 1'b1;

      repeat (4) begin
         step();
         checkOutput("rst_dac", dac_data, 12'h800);
         checkOutput("rst_rd", voice_rd, 0);
         checkOutput("rst_addr", voice_addr, 0);
         checkOutput("rst_busy", busy, 0);
         checkOutput("rst_strobe", sample_strobe, 0);
         checkOutput("rst_overrun", overrun, 0);
      end

      voices[0] = 16'sd800;
      applyStimulus(1);
      wait_done();
      checkOutput("single_voice", dac_data, 12'h864);

      for (int i = 0; i < NV; i++) voices[i] = 16'sh1000;
      applyStimulus(1);
      wait_done();
`ifdef POLY_MIXER_SATURATE_EN
      checkOutput("clip_high", dac_data, 12'hfff);
`else
      checkOutput("wrap_high", dac_data, 12'h800);
`endif

      for (int i = 0; i < NV; i++) voices[i] = -16'sd32768;
      applyStimulus(1);
      wait_done();
`ifdef POLY_MIXER_SATURATE_EN
      checkOutput("clip_low", dac_data, 12'h000);
`else
      checkOutput("wrap_low", dac_data, 12'h800);
`endif

      for (int i = 0; i < NV; i++) voices[i] = 16'sh1000;
      voice_mute = 8'hfe;
      applyStimulus(1);
      wait_done();
      checkOutput("muted", dac_data, 12'ha00);
      voice_mute = '0;

      for (int i = 0; i < NV; i++) voices[i] = 16'(i * 300 - 1000);
      t = cyc;
      applyStimulus(1);
      repeat (3) step();
      applyStimulus(0);
      while (cyc < t + 11) step();
      applyStimulus(1);
      wait_done();

      repeat (6) begin
         for (int i = 0; i < NV; i++) voices[i] = 16'($urandom);
         voice_mute = 8'($urandom);
         applyStimulus(1);
         wait_done();
      end
      voice_mute = '0;

      for (int i = 0; i < NV; i++) voices[i] = 16'sd2000;
      t = cyc;
      applyStimulus(1);
      repeat (4) step();
      reset = 1'b0;
      #1;
      checkOutput("abort_dac", dac_data, 12'h800);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_rd", voice_rd, 0);
      checkOutput("abort_strobe", sample_strobe, 0);
      sb.delete();
      rd_q.delete();
      ovr_q.delete();
      busy_from  = -1;
      busy_until = -2;
      repeat (2) step();
      reset = 1'b1;
      while (cyc < t + 13) step();
      voices[3] = -16'sd4000;
      applyStimulus(1);
      wait_done();

      step();
      checkOutput("overrun_left", ovr_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
